// File: rtl/i2s_pkg.sv
// Shared I2S definitions: event-transfer FSM states and parameter limits.
package i2s_pkg;

    // Event-transfer handshake states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } xfer_state_e;

    // Legal parameter ranges for the event-transfer arbiter
    localparam int unsigned NUM_EVT_MIN     = 2;
    localparam int unsigned NUM_EVT_MAX     = 16;
    localparam int unsigned SYNC_STAGES_MIN = 2;

    // Minimum ID width able to encode n requesters
    function automatic int unsigned id_w_min(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_rr_pick.sv
// Combinational round-robin picker.
// Ports: req    - request vector, one bit per requester
//        ptr    - highest-priority index; search wraps from NUM_EVT-1 to 0
//        gnt_vld- at least one request present
//        gnt_idx- index of the first request at or after ptr
module i2s_rr_pick
    import i2s_pkg::*;
#(
    parameter int unsigned NUM_EVT = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_EVT-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               gnt_vld,
    output logic [ID_W-1:0]    gnt_idx
);

    int unsigned j;

    // Scan NUM_EVT positions starting at ptr; first hit wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int unsigned k = 0; k < NUM_EVT; k++) begin
            j = 32'(ptr) + k;
            if (j >= NUM_EVT) begin
                j = j - NUM_EVT;
            end
            if (!gnt_vld && 1'(req >> j)) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/i2s_evt_xfer_arb.sv
// Event-transfer arbiter: latches clk1 event pulses as pending and grants them
// round-robin onto one 4-phase req/ack channel carrying the event ID to clk2.
// Ports: clk1, rst1_n   - clock, async active-low reset
//        enable         - allows new grants (in-flight handshake always completes)
//        evt_pulse      - one-cycle event pulses
//        xfer_req/id    - handshake request and granted ID (registered)
//        xfer_ack       - asynchronous acknowledge from clk2
//        pend, ovf      - pending latches, sticky overflow flags
//        ovf_clr        - write-1-to-clear for ovf
//        busy           - handshake in progress (state not IDLE)
module i2s_evt_xfer_arb
    import i2s_pkg::*;
#(
    parameter int unsigned NUM_EVT     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk1,
    input  logic               rst1_n,
    input  logic               enable,
    input  logic [NUM_EVT-1:0] evt_pulse,
    output logic               xfer_req,
    output logic [ID_W-1:0]    xfer_id,
    input  logic               xfer_ack,
    output logic [NUM_EVT-1:0] pend,
    output logic [NUM_EVT-1:0] ovf,
    input  logic [NUM_EVT-1:0] ovf_clr,
    output logic               busy
);

    // Elaboration-time parameter legality
    if ((NUM_EVT < NUM_EVT_MIN) || (NUM_EVT > NUM_EVT_MAX) ||
        (ID_W < id_w_min(NUM_EVT)) || (SYNC_STAGES < SYNC_STAGES_MIN)) begin : g_param_err
        $error("i2s_evt_xfer_arb: illegal NUM_EVT/ID_W/SYNC_STAGES");
    end

    xfer_state_e            state_q;
    xfer_state_e            state_d;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        rr_ptr_nxt;
    logic                   gnt_vld;
    logic [ID_W-1:0]        gnt_idx;
    logic                   grant_c;
    logic [NUM_EVT-1:0]     gnt_mask_c;
    logic [NUM_EVT-1:0]     ovf_set_c;

    i2s_rr_pick #(
        .NUM_EVT (NUM_EVT),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (pend),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Acknowledge synchronizer
    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a high ack_s in IDLE is stale and blocks new grants
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable && gnt_vld && !ack_s) state_d = REQ;
            REQ:     if (ack_s)                       state_d = DRAIN;
            DRAIN:   if (!ack_s)                      state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
    end

    // Grant strobe, pending clear mask and overflow detection
    always_comb begin
        grant_c    = (state_q == IDLE) && (state_d == REQ);
        gnt_mask_c = grant_c ? (NUM_EVT'(1) << gnt_idx) : '0;
        ovf_set_c  = evt_pulse & pend & ~gnt_mask_c;
        rr_ptr_nxt = (gnt_idx == ID_W'(NUM_EVT - 1)) ? '0 : gnt_idx + ID_W'(1);
    end

    // Registered outputs, pending/overflow latches and round-robin pointer.
    // A pulse coinciding with its own grant re-arms pend as a fresh event.
    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            xfer_req <= 1'b0;
            xfer_id  <= '0;
            pend     <= '0;
            ovf      <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            xfer_req <= (state_d == REQ);
            busy     <= (state_d != IDLE);
            pend     <= (pend & ~gnt_mask_c) | evt_pulse;
            ovf      <= (ovf & ~ovf_clr) | ovf_set_c;
            if (grant_c) begin
                xfer_id <= gnt_idx;
                rr_ptr  <= rr_ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_evt_xfer_arb.sv
// Directed self-checking bench for i2s_evt_xfer_arb with a clk2 responder model.
module tb_i2s_evt_xfer_arb;

    logic       clk1 = 1'b0;
    logic       clk2 = 1'b0;
    logic       rst1_n = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] evt_pulse = '0;
    logic [3:0] ovf_clr = '0;
    logic       xfer_req;
    logic [1:0] xfer_id;
    logic       xfer_ack;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic       busy;

    logic ack_hold = 1'b0;
    logic ack_auto = 1'b0;
    logic rsp_en   = 1'b1;
    int   rsp_cnt  = 0;
    logic prev_req = 1'b0;
    int   grants[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk1 = ~clk1;
    always #7 clk2 = ~clk2;

    assign xfer_ack = ack_hold | ack_auto;

    i2s_evt_xfer_arb #(
        .NUM_EVT     (4),
        .ID_W        (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk1      (clk1),
        .rst1_n    (rst1_n),
        .enable    (enable),
        .evt_pulse (evt_pulse),
        .xfer_req  (xfer_req),
        .xfer_id   (xfer_id),
        .xfer_ack  (xfer_ack),
        .pend      (pend),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    // Remote receiver: ack 3 clk2 cycles after req, drop ack when req drops
    always @(posedge clk2) begin
        if (!rsp_en) begin
            ack_auto <= 1'b0;
            rsp_cnt  <= 0;
        end else if (!ack_auto) begin
            if (xfer_req) begin
                if (rsp_cnt >= 2) ack_auto <= 1'b1;
                rsp_cnt <= rsp_cnt + 1;
            end else begin
                rsp_cnt <= 0;
            end
        end else if (!xfer_req) begin
            ack_auto <= 1'b0;
            rsp_cnt  <= 0;
        end
    end

    // Record the ID of every new request
    always @(negedge clk1) begin
        if (!rst1_n) begin
            prev_req <= 1'b0;
        end else begin
            if (xfer_req && !prev_req) grants.push_back(int'(xfer_id));
            prev_req <= xfer_req;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic [3:0] m);
        evt_pulse = m;
        @(negedge clk1);
        evt_pulse = '0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int i;
        i = 0;
        while (!(busy == 1'b0 && pend == 4'b0 && xfer_ack == 1'b0) && i < budget) begin
            @(negedge clk1);
            i++;
        end
        ok = (i < budget);
    endtask

    task automatic do_reset();
        rst1_n    = 1'b0;
        evt_pulse = '0;
        ovf_clr   = '0;
        enable    = 1'b1;
        ack_hold  = 1'b0;
        rsp_en    = 1'b1;
        repeat (3) @(negedge clk1);
        rst1_n = 1'b1;
        @(negedge clk1);
        grants.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk1);
        n_checks += 5;
        if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", xfer_req); end
        if (xfer_id !== 2'd0)  begin n_fail++; $display("FAIL reset_id: got %0d want 0", xfer_id); end
        if (pend !== 4'b0)     begin n_fail++; $display("FAIL reset_pend: got %b want 0000", pend); end
        if (ovf !== 4'b0)      begin n_fail++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst1_n = 1'b1;
        @(negedge clk1);
        grants.delete();
    endtask

    task automatic test_single();
        bit ok;
        pulse(4'b0100);
        n_checks += 2;
        if (pend !== 4'b0100) begin n_fail++; $display("FAIL single_pend_set: got %b want 0100", pend); end
        if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b want 0", xfer_req); end
        @(negedge clk1);
        n_checks += 4;
        if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b want 1", xfer_req); end
        if (xfer_id !== 2'd2)  begin n_fail++; $display("FAIL single_id: got %0d want 2", xfer_id); end
        if (pend !== 4'b0)     begin n_fail++; $display("FAIL single_pend_clr: got %b want 0000", pend); end
        if (busy !== 1'b1)     begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_done(200, ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL single_done: got timeout want idle"); end
        if (grants.size() != 1 || grants[0] != 2) begin
            n_fail++; $display("FAIL single_grants: got %0d grants want one grant of id 2", grants.size());
        end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int exp1[3] = '{0, 1, 3};
        int exp2[2] = '{0, 3};
        do_reset();
        pulse(4'b1011);
        wait_done(400, ok);
        n_checks++;
        if (!ok || grants.size() != 3) begin
            n_fail++; $display("FAIL simul_count: got %0d grants ok=%0b want 3", grants.size(), ok);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (grants[i] != exp1[i]) begin
                    n_fail++; $display("FAIL simul_order[%0d]: got %0d want %0d", i, grants[i], exp1[i]);
                end
            end
        end
        grants.delete();
        pulse(4'b1001);
        wait_done(400, ok);
        n_checks++;
        if (!ok || grants.size() != 2) begin
            n_fail++; $display("FAIL wrap_count: got %0d grants ok=%0b want 2", grants.size(), ok);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (grants[i] != exp2[i]) begin
                    n_fail++; $display("FAIL wrap_order[%0d]: got %0d want %0d", i, grants[i], exp2[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        enable = 1'b0;
        grants.delete();
        pulse(4'b0010);
        n_checks += 2;
        if (pend !== 4'b0010) begin n_fail++; $display("FAIL ovf_pend: got %b want 0010", pend); end
        if (ovf !== 4'b0)     begin n_fail++; $display("FAIL ovf_first: got %b want 0000", ovf); end
        pulse(4'b0010);
        n_checks++;
        if (ovf !== 4'b0010) begin n_fail++; $display("FAIL ovf_set: got %b want 0010", ovf); end
        ovf_clr = 4'b0010;
        @(negedge clk1);
        ovf_clr = 4'b0;
        n_checks++;
        if (ovf !== 4'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0000", ovf); end
        evt_pulse = 4'b0010;
        ovf_clr   = 4'b0010;
        @(negedge clk1);
        evt_pulse = 4'b0;
        ovf_clr   = 4'b0;
        n_checks++;
        if (ovf !== 4'b0010) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 0010", ovf); end
        ovf_clr = 4'b0010;
        @(negedge clk1);
        ovf_clr = 4'b0;
        enable  = 1'b1;
        wait_done(200, ok);
        n_checks += 2;
        if (!ok || grants.size() != 1 || grants[0] != 1) begin
            n_fail++; $display("FAIL ovf_grant: got %0d grants ok=%0b want one grant of id 1", grants.size(), ok);
        end
        if (ovf !== 4'b0) begin n_fail++; $display("FAIL ovf_final: got %b want 0000", ovf); end
    endtask

    task automatic test_pulse_on_grant();
        bit ok;
        enable = 1'b0;
        grants.delete();
        pulse(4'b0001);
        enable    = 1'b1;
        evt_pulse = 4'b0001;
        @(negedge clk1);
        evt_pulse = 4'b0;
        n_checks += 4;
        if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL pog_req: got %b want 1", xfer_req); end
        if (xfer_id !== 2'd0)  begin n_fail++; $display("FAIL pog_id: got %0d want 0", xfer_id); end
        if (pend !== 4'b0001)  begin n_fail++; $display("FAIL pog_pend: got %b want 0001", pend); end
        if (ovf !== 4'b0)      begin n_fail++; $display("FAIL pog_ovf: got %b want 0000", ovf); end
        wait_done(400, ok);
        n_checks++;
        if (!ok || grants.size() != 2 || grants[0] != 0 || grants[1] != 0) begin
            n_fail++; $display("FAIL pog_grants: got %0d grants ok=%0b want two grants of id 0", grants.size(), ok);
        end
    endtask

    task automatic test_enable_low();
        bit ok;
        logic saw_req;
        int exp[2] = '{1, 3};
        enable = 1'b0;
        grants.delete();
        pulse(4'b1010);
        saw_req = 1'b0;
        repeat (20) begin
            @(negedge clk1);
            saw_req = saw_req | xfer_req;
        end
        n_checks += 2;
        if (saw_req !== 1'b0) begin n_fail++; $display("FAIL en_low_req: got %b want 0", saw_req); end
        if (pend !== 4'b1010) begin n_fail++; $display("FAIL en_low_pend: got %b want 1010", pend); end
        enable = 1'b1;
        wait_done(400, ok);
        n_checks++;
        if (!ok || grants.size() != 2) begin
            n_fail++; $display("FAIL en_grant_count: got %0d grants ok=%0b want 2", grants.size(), ok);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (grants[i] != exp[i]) begin
                    n_fail++; $display("FAIL en_order[%0d]: got %0d want %0d", i, grants[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic saw_req;
        int i;
        rsp_en = 1'b0;
        pulse(4'b0100);
        i = 0;
        while (xfer_req !== 1'b1 && i < 10) begin
            @(negedge clk1);
            i++;
        end
        n_checks++;
        if (i >= 10) begin n_fail++; $display("FAIL rmid_req: got timeout want xfer_req 1"); end
        #2;
        ack_hold = 1'b1;
        rst1_n   = 1'b0;
        #1;
        n_checks += 5;
        if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req0: got %b want 0", xfer_req); end
        if (xfer_id !== 2'd0)  begin n_fail++; $display("FAIL rmid_id0: got %0d want 0", xfer_id); end
        if (pend !== 4'b0)     begin n_fail++; $display("FAIL rmid_pend0: got %b want 0000", pend); end
        if (ovf !== 4'b0)      begin n_fail++; $display("FAIL rmid_ovf0: got %b want 0000", ovf); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL rmid_busy0: got %b want 0", busy); end
        repeat (2) @(negedge clk1);
        rst1_n = 1'b1;
        repeat (4) @(negedge clk1);
        grants.delete();
        pulse(4'b0100);
        saw_req = 1'b0;
        repeat (10) begin
            @(negedge clk1);
            saw_req = saw_req | xfer_req;
        end
        n_checks += 3;
        if (saw_req !== 1'b0) begin n_fail++; $display("FAIL rmid_stale_req: got %b want 0", saw_req); end
        if (pend !== 4'b0100) begin n_fail++; $display("FAIL rmid_stale_pend: got %b want 0100", pend); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL rmid_stale_busy: got %b want 0", busy); end
        ack_hold = 1'b0;
        rsp_en   = 1'b1;
        wait_done(400, ok);
        n_checks++;
        if (!ok || grants.size() != 1 || grants[0] != 2) begin
            n_fail++; $display("FAIL rmid_grant: got %0d grants ok=%0b want one grant of id 2", grants.size(), ok);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_pulse_on_grant();
        test_enable_low();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
